// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and the iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// trial-subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  // Multiplicand gated by the current multiplier LSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
    assign addend[gi] = b[gi] & q_in[0];
  end

  always_comb begin
    sum     = {1'b0, rem_in} + {1'b0, addend};
    rem_sh  = {rem_in, q_in[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, b};
    rem_out = {sum[WIDTH:1]};
    q_out   = {sum[0], q_in[WIDTH-1:1]};
    if (is_div) begin
      // Borrow out of the trial subtract means restore the shifted remainder.
      if (diff[WIDTH+1]) begin
        rem_out = rem_sh[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], 1'b0};
      end else begin
        rem_out = diff[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with its own HI/LO pair; one result bit
// per cycle over WIDTH cycles, then a sign-fix cycle that writes HI/LO.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             is_div_reg, is_div_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic             dz_flag_reg, dz_flag_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             done_reg, done_next;
  logic             dz_reg, dz_next;

  op_t              op_e;
  logic             signed_op, is_div_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_q;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_reg),
    .rem_in  (rem_reg),
    .q_in    (q_reg),
    .b       (b_reg),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_comb begin
    op_e      = op_t'(op);
    signed_op = (op_e == MULT) || (op_e == DIV);
    is_div_op = (op_e == DIV) || (op_e == DIVU);
    // Most-negative magnitude wraps to itself, which is correct as unsigned.
    a_mag     = (signed_op && srca[WIDTH-1]) ? -srca : srca;
    b_mag     = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;
    prod      = {rem_reg, q_reg};
    prod_fix  = neg_q_reg ? -prod : prod;
    quo_fix   = neg_q_reg ? -q_reg : q_reg;
    rem_fix   = neg_r_reg ? -rem_reg : rem_reg;
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    rem_next     = rem_reg;
    q_next       = q_reg;
    b_next       = b_reg;
    is_div_next  = is_div_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    dz_flag_next = dz_flag_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    done_next    = 1'b0;
    dz_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (op_e)
            MULT, MULTU, DIV, DIVU: begin
              is_div_next  = is_div_op;
              count_next   = '0;
              rem_next     = '0;
              q_next       = a_mag;
              b_next       = b_mag;
              neg_q_next   = signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
              neg_r_next   = signed_op && srca[WIDTH-1];
              dz_flag_next = is_div_op && (srcb == '0);
              if (is_div_op && (srcb == '0)) begin
                q_next     = srca;  // raw dividend goes to HI on divide-by-zero
                state_next = FIX;
              end else begin
                state_next = RUN;
              end
            end
            MTHI:    hi_next = srca;
            MTLO:    lo_next = srca;
            default: ;
          endcase
        end
      end
      RUN: begin
        rem_next   = step_rem;
        q_next     = step_q;
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(WIDTH - 1)) state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        done_next  = 1'b1;
        dz_next    = dz_flag_reg;
        if (dz_flag_reg) begin
          hi_next = q_reg;
          lo_next = '1;
        end else if (is_div_reg) begin
          hi_next = rem_fix;
          lo_next = quo_fix;
        end else begin
          {hi_next, lo_next} = prod_fix;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      b_reg       <= '0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      dz_flag_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      rem_reg     <= rem_next;
      q_reg       <= q_next;
      b_reg       <= b_next;
      is_div_reg  <= is_div_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      dz_flag_reg <= dz_flag_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      done_reg    <= done_next;
      dz_reg      <= dz_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign div_by_zero = dz_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo at WIDTH=32 and WIDTH=8: stimulus pushes
// expected HI/LO, per-instance monitors pop and compare on each done pulse.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   t0      = 0;
  exp_t q32[$];
  exp_t q8[$];

  muldiv_hilo #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .srca(a32), .srcb(b32),
    .busy(busy32), .done(done32), .div_by_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_hilo #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .srca(a8), .srcb(b8),
    .busy(busy8), .done(done8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (!reset && done32 === 1'b1) begin
      exp_t e;
      $display("done w=32 hi=%h lo=%h dz=%b", hi32, lo32, dz32);
      if (q32.size() == 0) check("unexpected_done32", 1, 0);
      else begin
        e = q32.pop_front();
        check("hi32", hi32, e.hi);
        check("lo32", lo32, e.lo);
        check("dz32", dz32, e.dz);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done8 === 1'b1) begin
      exp_t e;
      $display("done w=8 hi=%h lo=%h dz=%b", hi8, lo8, dz8);
      if (q8.size() == 0) check("unexpected_done8", 1, 0);
      else begin
        e = q8.pop_front();
        check("hi8", {24'b0, hi8}, e.hi);
        check("lo8", {24'b0, lo8}, e.lo);
        check("dz8", dz8, e.dz);
      end
    end
  end

  task automatic launch(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input bit expect_it);
    exp_t e;
    @(negedge clk);
    e.hi = w8 ? {24'b0, ehi[7:0]} : ehi;
    e.lo = w8 ? {24'b0, elo[7:0]} : elo;
    e.dz = edz;
    if (expect_it) begin
      if (w8) q8.push_back(e);
      else q32.push_back(e);
    end
    if (w8) begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    start8  = 1'b0;
    start32 = 1'b0;
    // Operands must have been captured at start.
    a32 = ~a32; b32 = ~b32; a8 = ~a8; b8 = ~b8;
  endtask

  task automatic wait_done(input bit w8, input string name, input int lat, input int nbusy);
    int nb  = 0;
    bit got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (w8 ? busy8 : busy32) nb++;
      if (w8 ? done8 : done32) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({name, "_done"}, got, 1);
    check({name, "_latency"}, cyc - t0, lat);
    check({name, "_busy_cycles"}, nb, nbusy);
  endtask

  task automatic run_op(input bit w8, input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int lat;
    lat = edz ? 1 : (w8 ? 9 : 33);
    launch(w8, op, a, b, ehi, elo, edz, 1'b1);
    wait_done(w8, name, lat, lat);
  endtask

  initial begin
    reset = 1'b1;
    start32 = 1'b0; op32 = 3'd0; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = 3'd0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi32", hi32, 0);
    check("reset_lo32", lo32, 0);
    check("reset_busy32", busy32, 0);
    check("reset_done32", done32, 0);
    check("reset_dz32", dz32, 0);
    reset = 1'b0;

    run_op(0, "multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(0, "mult_m3x5",  MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op(0, "mult_minsq", MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_op(0, "mult_7xm2",  MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0);
    run_op(0, "div_m7_2",   DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(0, "div_7_m2",   DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op(0, "divu_7_2",   DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
    run_op(0, "div_min_m1", DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op(0, "divu_by0",   DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    run_op(0, "div_by0",    DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1);

    // MTHI / MTLO: single-cycle, no busy, no done
    @(negedge clk);
    start32 = 1'b1; op32 = MTHI; a32 = 32'hAAAA5555;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("mthi_hi", hi32, 32'hAAAA5555);
    check("mthi_busy", busy32, 0);
    @(negedge clk);
    start32 = 1'b1; op32 = MTLO; a32 = 32'h0F0F0F0F;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("mtlo_lo", lo32, 32'h0F0F0F0F);
    check("mtlo_hi_kept", hi32, 32'hAAAA5555);
    check("mtlo_busy", busy32, 0);

    // MTHI while busy is ignored; HI holds until the result write
    launch(0, MULTU, 32'd3, 32'd4, 32'h0, 32'hC, 1'b0, 1'b1);
    @(negedge clk);
    start32 = 1'b1; op32 = MTHI; a32 = 32'hDEADBEEF;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("mthi_while_busy_hi", hi32, 32'hAAAA5555);
    check("lo_held_in_run", lo32, 32'h0F0F0F0F);
    wait_done(0, "multu_inject", 33, 32);

    // Reset in the middle of RUN discards the operation
    launch(0, MULT, 32'd5, 32'd7, 32'h0, 32'd35, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrun_reset_busy", busy32, 0);
    check("midrun_reset_hi", hi32, 0);
    check("midrun_reset_lo", lo32, 0);
    check("midrun_reset_done", done32, 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    run_op(0, "divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // WIDTH=8 instance
    run_op(1, "w8_multu_max",  MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
    run_op(1, "w8_mult_m3x5",  MULT,  32'hFD, 32'h05, 32'hFF, 32'hF1, 1'b0);
    run_op(1, "w8_mult_minsq", MULT,  32'h80, 32'h80, 32'h40, 32'h00, 1'b0);
    run_op(1, "w8_div_m7_2",   DIV,   32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0);
    run_op(1, "w8_divu_7_2",   DIVU,  32'h07, 32'h02, 32'h01, 32'h03, 1'b0);
    run_op(1, "w8_div_min_m1", DIV,   32'h80, 32'hFF, 32'h00, 32'h80, 1'b0);
    run_op(1, "w8_divu_by0",   DIVU,  32'h34, 32'h00, 32'h34, 32'hFF, 1'b1);

    repeat (3) @(posedge clk);
    check("q32_drained", q32.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
